// File: rtl/mem_wb_stage_pkg.sv
// Shared widths and the control bundle carried by the EX/MEM and MEM/WB buffers.
package mem_wb_stage_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic branch;
    logic jump;
    logic mem_write;
    logic mem_read;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  function automatic logic word_aligned(input logic [1:0] byte_offset);
    return (byte_offset == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read, address checks.
module mem_wb_stage_data_mem
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              aligned,
  output logic              in_range
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     idx;

  // Low byte-offset bits are dropped, so a misaligned read returns the truncated word.
  assign idx      = addr[AW+1:2];
  assign aligned  = word_aligned(addr[1:0]);
  assign in_range = (addr[WORD_W-1:AW+2] == '0);
  assign rdata    = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (we && aligned && in_range) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data memory access, branch/jump redirect, wrong-path squash, MEM/WB register.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int SQUASH_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_W-1:0]     i_alu_result,
  input  logic [WORD_W-1:0]     i_read_rb_2,
  input  logic [WORD_W-1:0]     i_branch_address,
  input  logic [WORD_W-1:0]     i_jump_address,
  input  logic [REG_ADDR_W-1:0] i_inst_mux_br_write_address,
  input  logic                  i_zf,
  input  logic                  i_branch,
  input  logic                  i_jump,
  input  logic                  i_memWrite,
  input  logic                  i_memRead,
  input  logic                  i_regWrite,
  input  logic                  i_memToReg,
  output logic                  o_pc_src,
  output logic [WORD_W-1:0]     o_pc_target,
  output logic                  o_squash,
  output logic [WORD_W-1:0]     o_read_data,
  output logic [WORD_W-1:0]     o_alu_result,
  output logic [REG_ADDR_W-1:0] o_write_address,
  output logic                  o_regWrite,
  output logic                  o_memToReg,
  output logic                  o_misaligned,
  output logic                  o_range_err
);

  localparam int CW = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;

  ctrl_t             ctrl;
  logic [CW-1:0]     squash_cnt;
  logic              live;
  logic              take;
  logic              aligned;
  logic              in_range;
  logic              mem_we;
  logic              mem_access;
  logic [WORD_W-1:0] load_data;

  assign ctrl = '{branch:     i_branch,
                  jump:       i_jump,
                  mem_write:  i_memWrite,
                  mem_read:   i_memRead,
                  reg_write:  i_regWrite,
                  mem_to_reg: i_memToReg};

  assign o_squash    = (squash_cnt != '0);
  assign live        = ~o_squash;
  assign take        = live & ((ctrl.branch & i_zf) | ctrl.jump);
  assign o_pc_src    = take;
  assign o_pc_target = ctrl.jump ? i_jump_address : i_branch_address;

  // Reset cycle must not commit a store even though the array itself is never reset.
  assign mem_we     = rst_n & live & ctrl.mem_write;
  assign mem_access = live & (ctrl.mem_read | ctrl.mem_write);

  mem_wb_stage_data_mem #(
    .DEPTH(DEPTH)
  ) u_data_mem (
    .clk      (clk),
    .we       (mem_we),
    .addr     (i_alu_result),
    .wdata    (i_read_rb_2),
    .rdata    (load_data),
    .aligned  (aligned),
    .in_range (in_range)
  );

  // Branches arriving while squashing are wrong-path, so take already excludes them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      squash_cnt <= '0;
    end else if (take) begin
      squash_cnt <= CW'(SQUASH_CYCLES);
    end else if (squash_cnt != '0) begin
      squash_cnt <= squash_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_read_data     <= '0;
      o_alu_result    <= '0;
      o_write_address <= '0;
      o_regWrite      <= 1'b0;
      o_memToReg      <= 1'b0;
    end else begin
      o_read_data     <= load_data;
      o_alu_result    <= i_alu_result;
      o_write_address <= i_inst_mux_br_write_address;
      o_regWrite      <= ctrl.reg_write & live & ~(ctrl.mem_read & ~aligned);
      o_memToReg      <= ctrl.mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_misaligned <= 1'b0;
      o_range_err  <= 1'b0;
    end else begin
      if (mem_access && !aligned) begin
        o_misaligned <= 1'b1;
      end
      if (mem_access && aligned && !in_range) begin
        o_range_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scenario bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_result;
  logic [31:0] read_rb_2;
  logic [31:0] branch_address;
  logic [31:0] jump_address;
  logic [4:0]  wr_addr;
  logic        zf, branch, jump, mem_write, mem_read, reg_write, mem_to_reg;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        squash;
  logic [31:0] read_data;
  logic [31:0] alu_out;
  logic [4:0]  write_address;
  logic        reg_write_out, mem_to_reg_out;
  logic        misaligned, range_err;

  int total = 0;
  int bad   = 0;

  mem_wb_stage #(.DEPTH(64), .SQUASH_CYCLES(3)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .i_alu_result               (alu_result),
    .i_read_rb_2                (read_rb_2),
    .i_branch_address           (branch_address),
    .i_jump_address             (jump_address),
    .i_inst_mux_br_write_address(wr_addr),
    .i_zf                       (zf),
    .i_branch                   (branch),
    .i_jump                     (jump),
    .i_memWrite                 (mem_write),
    .i_memRead                  (mem_read),
    .i_regWrite                 (reg_write),
    .i_memToReg                 (mem_to_reg),
    .o_pc_src                   (pc_src),
    .o_pc_target                (pc_target),
    .o_squash                   (squash),
    .o_read_data                (read_data),
    .o_alu_result               (alu_out),
    .o_write_address            (write_address),
    .o_regWrite                 (reg_write_out),
    .o_memToReg                 (mem_to_reg_out),
    .o_misaligned               (misaligned),
    .o_range_err                (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nop();
    alu_result = 32'h0; read_rb_2 = 32'h0; branch_address = 32'h0; jump_address = 32'h0;
    wr_addr = 5'd0; zf = 0; branch = 0; jump = 0; mem_write = 0; mem_read = 0;
    reg_write = 0; mem_to_reg = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    nop(); alu_result = addr; read_rb_2 = data; mem_write = 1;
    tick();
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [4:0] rd);
    nop(); alu_result = addr; mem_read = 1; reg_write = 1; mem_to_reg = 1; wr_addr = rd;
  endtask

  task automatic test_reset();
    rst_n = 0; nop(); tick(); tick();
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL reset_read_data got=%h want=%h", read_data, 32'h0); end
    total++; if (alu_out !== 32'h0) begin bad++; $display("FAIL reset_alu_result got=%h want=%h", alu_out, 32'h0); end
    total++; if ({write_address, reg_write_out, mem_to_reg_out} !== 7'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", {write_address, reg_write_out, mem_to_reg_out}); end
    total++; if ({squash, misaligned, range_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {squash, misaligned, range_err}); end
    rst_n = 1;
  endtask

  task automatic test_store_load();
    do_store(32'h10, 32'hDEADBEEF);
    set_load(32'h10, 5'd5);
    tick();
    total++; if (read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL store_load_data got=%h want=%h", read_data, 32'hDEADBEEF); end
    total++; if ({reg_write_out, mem_to_reg_out} !== 2'b11) begin bad++; $display("FAIL store_load_ctrl got=%b want=11", {reg_write_out, mem_to_reg_out}); end
    total++; if (write_address !== 5'd5 || alu_out !== 32'h10) begin bad++; $display("FAIL store_load_pass got=%h/%h want=05/00000010", write_address, alu_out); end
  endtask

  task automatic test_branch_squash();
    do_store(32'h20, 32'h11111111);
    nop(); branch = 1; zf = 1; branch_address = 32'h40; jump_address = 32'h80; reg_write = 1; wr_addr = 5'd3;
    #1;
    total++; if (pc_src !== 1'b1 || pc_target !== 32'h40) begin bad++; $display("FAIL branch_redirect got=%b/%h want=1/00000040", pc_src, pc_target); end
    tick();
    total++; if (reg_write_out !== 1'b1 || squash !== 1'b1) begin bad++; $display("FAIL branch_commits got=%b/%b want=1/1", reg_write_out, squash); end
    nop(); reg_write = 1; alu_result = 32'h5;
    tick();
    total++; if (reg_write_out !== 1'b0) begin bad++; $display("FAIL squash1_regwrite got=%b want=0", reg_write_out); end
    nop(); reg_write = 1; alu_result = 32'h20; read_rb_2 = 32'h22222222; mem_write = 1;
    tick();
    total++; if (reg_write_out !== 1'b0) begin bad++; $display("FAIL squash2_regwrite got=%b want=0", reg_write_out); end
    nop(); reg_write = 1;
    tick();
    total++; if (reg_write_out !== 1'b0 || squash !== 1'b0) begin bad++; $display("FAIL squash3_end got=%b/%b want=0/0", reg_write_out, squash); end
    set_load(32'h20, 5'd9);
    tick();
    total++; if (reg_write_out !== 1'b1 || read_data !== 32'h11111111) begin bad++; $display("FAIL after_squash got=%b/%h want=1/11111111", reg_write_out, read_data); end
  endtask

  task automatic test_jump_during_squash();
    nop(); branch = 1; zf = 1; branch_address = 32'h40;
    tick();
    nop(); tick();
    nop(); jump = 1; jump_address = 32'h99;
    #1;
    total++; if (pc_src !== 1'b0 || pc_target !== 32'h99) begin bad++; $display("FAIL jump_in_squash got=%b/%h want=0/00000099", pc_src, pc_target); end
    tick();
    total++; if (squash !== 1'b1) begin bad++; $display("FAIL squash_still got=%b want=1", squash); end
    nop(); tick();
    total++; if (squash !== 1'b0) begin bad++; $display("FAIL no_reload got=%b want=0", squash); end
    nop(); branch = 1; zf = 0; branch_address = 32'h44; jump_address = 32'h200;
    #1;
    total++; if (pc_src !== 1'b0 || pc_target !== 32'h44) begin bad++; $display("FAIL branch_not_taken got=%b/%h want=0/00000044", pc_src, pc_target); end
    zf = 1; jump = 1;
    #1;
    total++; if (pc_src !== 1'b1 || pc_target !== 32'h200) begin bad++; $display("FAIL jump_wins got=%b/%h want=1/00000200", pc_src, pc_target); end
    tick();
    nop(); tick(); tick(); tick();
    total++; if (squash !== 1'b0) begin bad++; $display("FAIL squash_drain got=%b want=0", squash); end
  endtask

  task automatic test_misaligned();
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL misaligned_clear got=%b want=0", misaligned); end
    set_load(32'h13, 5'd4);
    tick();
    total++; if (misaligned !== 1'b1 || reg_write_out !== 1'b0) begin bad++; $display("FAIL misaligned_load got=%b/%b want=1/0", misaligned, reg_write_out); end
    total++; if (read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL misaligned_trunc got=%h want=deadbeef", read_data); end
    do_store(32'h12, 32'h00000BAD);
    set_load(32'h10, 5'd4);
    tick();
    total++; if (read_data !== 32'hDEADBEEF || misaligned !== 1'b1 || range_err !== 1'b0) begin bad++; $display("FAIL misaligned_store got=%h/%b/%b want=deadbeef/1/0", read_data, misaligned, range_err); end
  endtask

  task automatic test_range();
    do_store(32'h0, 32'hA5A5A5A5);
    total++; if (range_err !== 1'b0) begin bad++; $display("FAIL range_clear got=%b want=0", range_err); end
    do_store(32'h100, 32'h12345678);
    total++; if (range_err !== 1'b1) begin bad++; $display("FAIL range_store_flag got=%b want=1", range_err); end
    set_load(32'h100, 5'd6);
    tick();
    total++; if (read_data !== 32'h0 || reg_write_out !== 1'b1) begin bad++; $display("FAIL range_load got=%h/%b want=00000000/1", read_data, reg_write_out); end
    set_load(32'h0, 5'd6);
    tick();
    total++; if (read_data !== 32'hA5A5A5A5 || range_err !== 1'b1) begin bad++; $display("FAIL range_drop got=%h/%b want=a5a5a5a5/1", read_data, range_err); end
  endtask

  task automatic test_reset_mid_squash();
    nop(); branch = 1; zf = 1; branch_address = 32'h40;
    tick();
    nop(); tick();
    rst_n = 0; nop(); alu_result = 32'h0; read_rb_2 = 32'hFFFFFFFF; mem_write = 1; reg_write = 1; wr_addr = 5'd2;
    tick();
    total++; if ({squash, misaligned, range_err} !== 3'b000) begin bad++; $display("FAIL rst_mid_flags got=%b want=000", {squash, misaligned, range_err}); end
    total++; if (read_data !== 32'h0 || alu_out !== 32'h0 || {write_address, reg_write_out, mem_to_reg_out} !== 7'h0) begin bad++; $display("FAIL rst_mid_outs got=%h/%h/%h want=0/0/0", read_data, alu_out, {write_address, reg_write_out, mem_to_reg_out}); end
    rst_n = 1;
    set_load(32'h0, 5'd7);
    tick();
    total++; if (reg_write_out !== 1'b1 || write_address !== 5'd7 || read_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL post_reset got=%b/%h/%h want=1/07/a5a5a5a5", reg_write_out, write_address, read_data); end
    set_load(32'h10, 5'd1);
    tick();
    total++; if (read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL mem_kept got=%h want=deadbeef", read_data); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_branch_squash();
    test_jump_during_squash();
    test_misaligned();
    test_range();
    test_reset_mid_squash();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline; consumes the registered EX/MEM bundle and produces the registered MEM/WB bundle for write-back.
- Contains the word-addressed data memory, branch/jump resolution with the PC redirect, and a squash counter that kills wrong-path instructions arriving behind a taken redirect.
- Raises sticky misaligned-access and out-of-range error flags.

Parameters:
- DEPTH, 64, number of 32-bit data-memory words (power of two).
- SQUASH_CYCLES, 3, number of following instructions squashed after a taken redirect (0 disables squashing).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_alu_result  in  32  byte address, or ALU result passthrough.
- i_read_rb_2  in  32  store data.
- i_branch_address  in  32  branch target.
- i_jump_address  in  32  jump target.
- i_inst_mux_br_write_address  in  5  destination register.
- i_zf  in  1  ALU zero flag.
- i_branch, i_jump, i_memWrite, i_memRead, i_regWrite, i_memToReg  in  1 each  control bits.
- o_pc_src  out  1  redirect request to fetch (combinational).
- o_pc_target  out  32  redirect target (combinational).
- o_squash  out  1  high while the squash counter is nonzero.
- o_read_data  out  32  MEM/WB loaded word.
- o_alu_result  out  32  MEM/WB ALU result.
- o_write_address  out  5  MEM/WB destination register.
- o_regWrite, o_memToReg  out  1 each  MEM/WB control.
- o_misaligned  out  1  sticky error flag.
- o_range_err  out  1  sticky error flag.

Behaviour:
- Definitions:
  - live = ~o_squash.
  - aligned = (i_alu_result[1:0] == 0).
  - in_range = (i_alu_result >> 2) < DEPTH.
  - Word index = i_alu_result[log2(DEPTH)+1:2].
- Redirect:
  - take = live & ((i_branch & i_zf) | i_jump).
  - o_pc_src = take.
  - o_pc_target = i_jump ? i_jump_address : i_branch_address; jump wins if both are set.
  - When not taken, o_pc_target still drives that mux; fetch ignores it.
- Squash counter (width clog2(SQUASH_CYCLES+1)):
  - Reset sets the counter to 0.
  - On take, load SQUASH_CYCLES.
  - Otherwise, if nonzero, decrement by 1.
  - A branch/jump arriving while o_squash=1 is ignored and does not reload the counter.
- Store:
  - Write mem[index] <= i_read_rb_2 at the clock edge when live & i_memWrite & aligned & in_range.
  - A misaligned or out-of-range store is dropped and memory is unchanged.
- Load: asynchronous array read, captured into the MEM/WB register at the same edge; one-cycle latency from the EX/MEM inputs.
  - Returns mem[index] when aligned & in_range.
  - Returns 0 when out of range.
  - Returns the word at the truncated index (low bits ignored) when misaligned.
- MEM/WB register, every edge:
  - o_alu_result <= i_alu_result.
  - o_read_data <= load value.
  - o_write_address <= i_inst_mux_br_write_address.
  - o_memToReg <= i_memToReg.
  - o_regWrite <= i_regWrite & live & ~(i_memRead & ~aligned).
- Errors (sticky until reset, only for live accesses):
  - o_misaligned sets on (i_memRead | i_memWrite) & ~aligned.
  - o_range_err sets on (i_memRead | i_memWrite) & aligned & ~in_range.
- Reset (rst_n=0 at edge):
  - All MEM/WB outputs, the counter and both error flags go to 0.
  - Memory contents are not cleared.
  - Reset during squashing aborts the squash.
  - A store presented in the reset cycle is dropped.
- A redirecting instruction itself is live: its regWrite and memory effects commit normally.
- Every combinational output depends only on current inputs and counter state.

Decomposition:
- Shared package holds:
  - WORD_W=32 and REG_ADDR_W=5.
  - An enum-free control bundle struct (branch, jump, memWrite, memRead, regWrite, memToReg) reused by both pipeline buffers.
- One natural sub-module: data_mem (DEPTH-word array, synchronous write, asynchronous read, address-range check); everything else stays in mem_wb_stage.

Test Plan:
- Store then load: store 0xDEADBEEF at addr 0x10, next cycle load 0x10 -> o_read_data=0xDEADBEEF one edge later, o_regWrite=1, o_memToReg=1.
- Taken branch: i_branch=1, i_zf=1, target 0x40 -> o_pc_src=1, o_pc_target=0x40. Next 3 instructions (regWrite=1, one store to 0x20) then have o_regWrite=0 and mem[8] unchanged. The 4th instruction commits.
- Jump during squash: jump presented on the 2nd squashed cycle -> o_pc_src=0, counter not reloaded, squash ends after 3 cycles total. Also apply branch+jump together when live -> o_pc_target=i_jump_address.
- Misaligned load at 0x13 -> o_misaligned=1 and stays 1; o_regWrite=0 for that load; memory unchanged on a misaligned store to 0x12.
- Range: store at address DEPTH*4 (0x100) -> dropped, o_range_err=1; load at 0x100 -> o_read_data=0.
- Reset mid-squash: rst_n=0 one cycle after a taken branch -> o_squash=0, all MEM/WB outputs 0, error flags 0. An instruction after reset with regWrite=1 commits.
